// File: rtl/modulo_iter.sv
// modulo_iter: multi-cycle unsigned remainder (a mod b), one bit per cycle,
// driven by the execute stage through a start/busy/done handshake.
//
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   start          request pulse, accepted only while idle
//   a, b           dividend and divisor, captured on the accepting edge
//   busy           high whenever the unit is not idle
//   done           one-cycle pulse; c, banderas and dz valid from here on
//   c              registered remainder
//   banderas       registered flags {N, Z, C, V}; only Z is ever set
//   dz             registered divide-by-zero indication
module modulo_iter #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] c,
    output logic [3:0]   banderas,
    output logic         dz
);

    localparam int cw = $clog2(n + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t        state;
    logic [n-1:0]  q;
    logic [n-1:0]  d;
    // The partial remainder is always below d between iterations, so its
    // top bit is only needed inside the shifted/compared value.
    logic [n-1:0]  r;
    logic [cw-1:0] cnt;

    logic [n:0]    r_shift;
    logic [n:0]    d_ext;
    logic [n:0]    r_next;

    always_comb begin
        r_shift = {r, q[n-1]};
        d_ext   = {1'b0, d};
        r_next  = r_shift;
        if (r_shift >= d_ext) begin
            r_next = r_shift - d_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            c        <= '0;
            banderas <= 4'b0000;
            dz       <= 1'b0;
            cnt      <= '0;
            q        <= '0;
            d        <= '0;
            r        <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (b == '0) begin
                            // Divide by zero: result is the dividend itself.
                            state    <= DONE;
                            done     <= 1'b1;
                            c        <= a;
                            dz       <= 1'b1;
                            banderas <= {1'b0, a == '0, 2'b00};
                        end else begin
                            state <= CALC;
                            q     <= a;
                            d     <= b;
                            r     <= '0;
                            cnt   <= cw'(n);
                        end
                    end
                end
                CALC: begin
                    q   <= q << 1;
                    r   <= r_next[n-1:0];
                    cnt <= cnt - cw'(1);
                    if (cnt == cw'(1)) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        c        <= r_next[n-1:0];
                        dz       <= 1'b0;
                        banderas <= {1'b0, r_next == '0, 2'b00};
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_modulo_iter.sv
// tb_modulo_iter: self-checking bench for modulo_iter (n = 32).
// Table vectors and random operands feed a scoreboard; corner cases are hand-written.
module tb_modulo_iter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] c;
    logic [3:0]  banderas;
    logic        dz;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] c;
        logic [3:0]  fl;
        logic        dz;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [3:0]  fl;
        logic        dz;
        int          lat;
    } vec_t;

    exp_t sb[$];

    modulo_iter #(.n(32)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .a(a),
        .b(b),
        .busy(busy),
        .done(done),
        .c(c),
        .banderas(banderas),
        .dz(dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_,
                         input logic [31:0] ec, input logic [3:0] efl,
                         input logic edz, input int elat);
        exp_t e;
        int   cyc;
        bit   busy_ok;
        e.c  = ec;
        e.fl = efl;
        e.dz = edz;
        sb.push_back(e);
        a     = ta;
        b     = tb_;
        start = 1'b1;
        step();
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        cyc     = 1;
        busy_ok = 1'b1;
        while (!done && cyc < 100) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            step();
            cyc++;
        end
        if (busy !== 1'b1) busy_ok = 1'b0;
        check("done_seen", {63'd0, done}, 64'd1);
        check("latency", 64'(cyc), 64'(elat));
        check("busy_window", {63'd0, busy_ok}, 64'd1);
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("sb_empty", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("c", {32'd0, c}, {32'd0, e.c});
                check("banderas", {60'd0, banderas}, {60'd0, e.fl});
                check("dz", {63'd0, dz}, {63'd0, e.dz});
            end
        end else begin
            sb.delete();
        end
        step();
        check("busy_after", {63'd0, busy}, 64'd0);
        check("done_single", {63'd0, done}, 64'd0);
    endtask

    vec_t vt[9];

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] rc;
        int          dones;
        int          cyc;

        vt[0] = '{32'd17, 32'd5, 32'd2, 4'b0000, 1'b0, 33};
        vt[1] = '{32'd20, 32'd5, 32'd0, 4'b0100, 1'b0, 33};
        vt[2] = '{32'd3, 32'd7, 32'd3, 4'b0000, 1'b0, 33};
        vt[3] = '{32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 4'b0000, 1'b0, 33};
        vt[4] = '{32'hFFFFFFFF, 32'd1, 32'd0, 4'b0100, 1'b0, 33};
        vt[5] = '{32'h7FFFFFFE, 32'hFFFFFFFF, 32'h7FFFFFFE, 4'b0000, 1'b0, 33};
        vt[6] = '{32'h00001234, 32'd0, 32'h00001234, 4'b0000, 1'b1, 1};
        vt[7] = '{32'd0, 32'd0, 32'd0, 4'b0100, 1'b1, 1};
        vt[8] = '{32'd0, 32'd9, 32'd0, 4'b0100, 1'b0, 33};

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        step();
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_c", {32'd0, c}, 64'd0);
        check("rst_banderas", {60'd0, banderas}, 64'd0);
        check("rst_dz", {63'd0, dz}, 64'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 9; i++) begin
            do_op(vt[i].a, vt[i].b, vt[i].c, vt[i].fl, vt[i].dz, vt[i].lat);
        end

        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if (i == 5) rb = 32'd0;
            rc = (rb == 0) ? ra : ra % rb;
            do_op(ra, rb, rc, {1'b0, rc == 0, 2'b00}, rb == 0,
                  (rb == 0) ? 1 : 33);
        end

        // Start pulses in cycles 5 and 33 of an active op are ignored.
        a     = 32'd17;
        b     = 32'd5;
        start = 1'b1;
        step();
        dones = 0;
        for (cyc = 1; cyc < 34; cyc++) begin
            if (done === 1'b1) begin
                dones++;
                check("ign_c", {32'd0, c}, 64'd2);
                check("ign_cycle", 64'(cyc), 64'd33);
            end
            if (cyc == 5 || cyc == 33) begin
                start = 1'b1;
                a     = 32'd100;
                b     = 32'd3;
            end else begin
                start = 1'b0;
            end
            step();
        end
        start = 1'b0;
        check("ign_dones", 64'(dones), 64'd1);
        check("ign_idle34", {63'd0, busy}, 64'd0);
        do_op(32'd100, 32'd3, 32'd1, 4'b0000, 1'b0, 33);

        // Abort in cycle 10, with outputs previously holding a dz result.
        do_op(32'h00001234, 32'd0, 32'h00001234, 4'b0000, 1'b1, 1);
        a     = 32'd17;
        b     = 32'd5;
        start = 1'b1;
        step();
        start = 1'b0;
        dones = 0;
        for (cyc = 1; cyc < 10; cyc++) begin
            if (done === 1'b1) dones++;
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_c", {32'd0, c}, 64'd0);
        check("abort_banderas", {60'd0, banderas}, 64'd0);
        check("abort_dz", {63'd0, dz}, 64'd0);
        for (int i = 0; i < 30; i++) begin
            if (done === 1'b1) dones++;
            step();
        end
        check("abort_no_done", 64'(dones), 64'd0);
        do_op(32'd100, 32'd7, 32'd2, 4'b0000, 1'b0, 33);

        // rst wins over a simultaneous start.
        a     = 32'd5;
        b     = 32'd3;
        start = 1'b1;
        rst   = 1'b1;
        step();
        start = 1'b0;
        rst   = 1'b0;
        check("rst_start_busy", {63'd0, busy}, 64'd0);
        step();
        check("rst_start_idle", {63'd0, busy}, 64'd0);

        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/modulo_iter.md
# modulo_iter

Multi-cycle sequential unsigned modulo unit for the CPU ALU path. It computes a mod b with a restoring shift-subtract loop, one bit per cycle, instead of a single-cycle combinational remainder. The execute stage controls it through a start/busy/done handshake. The flag format matches the other ALU units, so the flag-write logic treats this unit like any other.

## Interface
- n, default 32, operand and result width in bits (n >= 2).
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- a  in  n  dividend, unsigned; sampled on the accepting edge.
- b  in  n  divisor, unsigned; sampled on the accepting edge.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse; c and banderas are valid from this cycle on.
- c  out  n  remainder, registered.
- banderas  out  4  flags {N, Z, C, V}, registered. N=0, C=0, V=0 always; Z = (c == 0).
- dz  out  1  divide-by-zero indication, registered, valid with done.

## Operation
- **States:** IDLE, CALC, DONE.
- **IDLE → CALC** (start=1, b≠0):
  - Latch q ← a, d ← b.
  - Clear the partial remainder r (n+1 bits).
  - Load the iteration counter cnt ← n.
- **IDLE → DONE** (start=1, b=0):
  - c ← a, dz ← 1, banderas ← {0, a==0, 0, 0}.
  - No iterations run.
- **CALC, each cycle:**
  - r' = {r[n-1:0], q[n-1]}, then q ← q << 1.
  - If r' >= {0, d}, r ← r' − d; otherwise r ← r'.
  - cnt ← cnt − 1.
  - When cnt reaches 1 in the current cycle, perform the final iteration and go to DONE. On that same edge, write c ← final r[n-1:0], dz ← 0, banderas ← {0, final r==0, 0, 0}.
- **DONE:**
  - done=1 for exactly one cycle.
  - Unconditional transition to IDLE.
  - start is ignored in DONE.
- **Output retention:** c, banderas and dz hold their values until the next completion or reset.
- **Ignored requests:** start while busy=1 is ignored. The operation in flight is not disturbed and nothing is queued.
- **Input stability:** a and b may change freely after the accepting edge.
- **Arithmetic:**
  - Unsigned only; the remainder always satisfies c < b for b≠0.
  - The r comparison/subtract is n+1 bits wide so no bit is lost when d has its MSB set.

## Timing
- **Reset values:** state=IDLE, busy=0, done=0, c=0, banderas=4'b0000, dz=0, cnt=0.
- **Reset mid-operation:** rst=1 in CALC or DONE aborts. The next state is IDLE with the reset values above, and no done pulse is produced.
- **Cycle numbering:** cycle 0 is the cycle in which start=1 is sampled in IDLE.
- **Normal latency (b≠0):**
  - busy=1 in cycles 1..n+1.
  - done=1 in cycle n+1, with c and banderas valid in that cycle.
  - busy=0 from cycle n+2.
  - For n=32: done in cycle 33.
- **Divide-by-zero latency:** done=1 and busy=1 in cycle 1; busy=0 from cycle 2.
- **Back-to-back throughput:** the earliest next accept is cycle n+2, one operation per n+2 cycles.
- **Outputs:** registered only; there is no combinational path from inputs to outputs.
- **start and rst together:** rst wins.

## Test plan
- **Basic remainder:** rst 1 cycle; start with a=17, b=5 → done in cycle 33, c=2, banderas=0000, dz=0, busy high in cycles 1..33.
- **Exact division and zero remainder:**
  - a=20, b=5 → c=0, banderas=0100.
  - a=3, b=7 → c=3, banderas=0000.
- **Width edges:**
  - a=0xFFFFFFFF, b=0x80000000 → c=0x7FFFFFFF.
  - a=0xFFFFFFFF, b=1 → c=0, Z=1.
  - a=0x7FFFFFFE, b=0xFFFFFFFF → c=0x7FFFFFFE.
- **Divide by zero:**
  - a=0x1234, b=0 → done in cycle 1, c=0x1234, dz=1, banderas=0000.
  - a=0, b=0 → banderas=0100.
- **Ignored start:** re-pulse start with new a/b in cycles 5 and 33 of an active 17 mod 5 operation → result still 2, a single done pulse. The new request is accepted only when issued in cycle 34 or later.
- **Abort:** rst in cycle 10 of an operation → no done pulse, all outputs return to reset values. A following 100 mod 7 → c=2 in cycle 33 of that operation.
